// File: rtl/ram_arb_if.sv
// Master-side bus of the three-port RAM arbiter.
// Three private strobe/ack ports share one read-data bus (m_dout).
`timescale 1ns/1ps
interface ram_arb_if;
  logic        m0_stb, m1_stb, m2_stb;
  logic        m0_we, m1_we, m2_we;
  logic [26:2] m0_addr, m1_addr, m2_addr;
  logic [31:0] m0_din, m1_din, m2_din;
  logic [31:0] m_dout;
  logic        m0_ack, m1_ack, m2_ack;

  // Requester side: drives requests, receives completions.
  modport master (
    output m0_stb, m1_stb, m2_stb,
    output m0_we, m1_we, m2_we,
    output m0_addr, m1_addr, m2_addr,
    output m0_din, m1_din, m2_din,
    input  m_dout,
    input  m0_ack, m1_ack, m2_ack
  );

  // Arbiter side.
  modport slave (
    input  m0_stb, m1_stb, m2_stb,
    input  m0_we, m1_we, m2_we,
    input  m0_addr, m1_addr, m2_addr,
    input  m0_din, m1_din, m2_din,
    output m_dout,
    output m0_ack, m1_ack, m2_ack
  );
endinterface

// File: rtl/ram_arb.sv
// ram_arb: shares the single ram block between instruction fetch (m0),
// data access (m1) and video/DMA (m2). One registered request is presented
// to ram at a time; a per-request watchdog aborts requests ram never acks.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority m0 > m1 > m2.
`timescale 1ns/1ps
module ram_arb #(
  parameter int TMO_CYC = 1023  // 1..1023 cycles before a granted request is aborted
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active low
  ram_arb_if.slave    m,
  output logic        ram_stb,
  output logic        ram_we,
  output logic [26:2] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        tmo,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TMO_CYC - 1);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;

  state_t      state;
  logic [9:0]  cnt;
  logic [2:0]  ack_q;
  logic [31:0] dout_q;

  logic [2:0]  req;
  logic [1:0]  win;
  logic        sel_we;
  logic [26:2] sel_addr;
  logic [31:0] sel_din;

`ifdef RAM_ARB_RR_EN
  logic [1:0]  ptr;  // last granted port; the search starts just after it
`endif

  assign req = {m.m2_stb, m.m1_stb, m.m0_stb};

  assign m.m0_ack = ack_q[0];
  assign m.m1_ack = ack_q[1];
  assign m.m2_ack = ack_q[2];
  assign m.m_dout = dout_q;

  // Pick the winning port among the active strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win = 2'd0;
`ifdef RAM_ARB_RR_EN
    case (ptr)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`else
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
`endif
  end

  // Route the winner's request fields to the request registers.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    case (win)
      2'd0: begin
        sel_we   = m.m0_we;
        sel_addr = m.m0_addr;
        sel_din  = m.m0_din;
      end
      2'd1: begin
        sel_we   = m.m1_we;
        sel_addr = m.m1_addr;
        sel_din  = m.m1_din;
      end
      default: begin
        sel_we   = m.m2_we;
        sel_addr = m.m2_addr;
        sel_din  = m.m2_din;
      end
    endcase
  end

  // Arbitration FSM: grant in IDLE, wait for ram or the watchdog in BUSY,
  // present the one-cycle ack/tmo in DONE.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state     <= IDLE;
      ram_stb   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      dout_q    <= '0;
      ack_q     <= '0;
      tmo       <= 1'b0;
      gnt       <= 2'd0;
      cnt       <= '0;
`ifdef RAM_ARB_RR_EN
      ptr       <= 2'd2;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack_q <= '0;
          tmo   <= 1'b0;
          if (|req) begin
            gnt       <= win;
            ram_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_din;
            ram_stb   <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
`ifdef RAM_ARB_RR_EN
            ptr       <= win;
`endif
          end
        end

        BUSY: begin
          // A ram ack in the last watchdog cycle still completes normally.
          if (ram_ack) begin
            dout_q  <= ram_rdata;
            ack_q   <= 3'b001 << gnt;
            ram_stb <= 1'b0;
            state   <= DONE;
          end else if (cnt == TMO_LAST) begin
            ram_stb <= 1'b0;
            tmo     <= 1'b1;
            state   <= DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 10'd1;
          end
        end

        DONE: begin
          // Requesters still show their old strobe here, so no grant.
          ack_q <= '0;
          tmo   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
